// File: rtl/rfp_dac_loader_if.sv
// Wishbone master/slave link between the DAC loader and the RFP I2C bridge.
// Only wb_dat_i[7:0] carries meaning; the upper bytes are always zero from the core.
interface rfp_dac_loader_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [15:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/rfp_dac_loader.sv
// Autonomous Wishbone master that initialises the DAC-bus I2C core and then
// sends one 3-byte DAC write per request, polling SR between bytes.
module rfp_dac_loader #(
  parameter logic [15:0] PRESCALE = 16'd199,
  parameter logic [6:0]  DAC_ADDR = 7'h60,
  parameter int unsigned POLL_MAX = 50000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_i,
  input  logic [1:0]       chan_i,
  input  logic [11:0]      value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             nack_o,
  output logic             fault_o,
  rfp_dac_loader_if.master wb
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXR    = 3'd3;
  localparam logic [2:0] REG_CR     = 3'd4;

  typedef enum logic [3:0] {
    INIT_LO, INIT_HI, INIT_CTR, IDLE, WR_TXR, WR_CR, RD_SR, STOP_CR, STOP_POLL, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [2:0]      reg_q, reg_d;
  logic [7:0]      dat_q, dat_d;
  logic [1:0]      byte_q, byte_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [1:0]      chan_q, chan_d;
  logic [11:0]     value_q, value_d;
  logic            nack_q, nack_d;
  logic            fault_q, fault_d;

  logic            acc_req, acc_we;
  logic [2:0]      acc_reg;
  logic [7:0]      acc_dat;
  logic [7:0]      tx_byte, cr_byte;
  logic [PW-1:0]   poll_inc;
  logic            tip, al, rxack;
  logic            unused_dat;

  assign tip        = wb.wb_dat_i[1];
  assign al         = wb.wb_dat_i[5];
  assign rxack      = wb.wb_dat_i[7];
  assign unused_dat = ^{wb.wb_dat_i[31:8], wb.wb_dat_i[6], wb.wb_dat_i[4:2], wb.wb_dat_i[0]};
  assign poll_inc   = poll_q + PW'(1);

  always_comb begin
    case (byte_q)
      2'd0:    begin tx_byte = {DAC_ADDR, 1'b0};                 cr_byte = 8'h90; end
      2'd1:    begin tx_byte = {2'b01, chan_q, value_q[11:8]};   cr_byte = 8'h10; end
      default: begin tx_byte = value_q[7:0];                     cr_byte = 8'h50; end
    endcase
  end

  // Which register access, if any, the current state performs.
  always_comb begin
    acc_req = 1'b1;
    acc_we  = 1'b1;
    acc_reg = REG_CR;
    acc_dat = 8'h00;
    case (state_q)
      INIT_LO:   begin acc_reg = REG_PRERLO; acc_dat = PRESCALE[7:0];  end
      INIT_HI:   begin acc_reg = REG_PRERHI; acc_dat = PRESCALE[15:8]; end
      INIT_CTR:  begin acc_reg = REG_CTR;    acc_dat = 8'h80;          end
      WR_TXR:    begin acc_reg = REG_TXR;    acc_dat = tx_byte;        end
      WR_CR:     acc_dat = cr_byte;
      RD_SR:     acc_we  = 1'b0;
      STOP_CR:   acc_dat = 8'h40;
      STOP_POLL: acc_we  = 1'b0;
      default:   acc_req = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the branches so no path can infer a latch.
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    byte_d  = byte_q;
    poll_d  = poll_q;
    chan_d  = chan_q;
    value_d = value_q;
    nack_d  = nack_q;
    fault_d = fault_q;

    if (acc_req && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = acc_we;
      reg_d = acc_reg;
      dat_d = acc_dat;
    end else if (cyc_q && wb.wb_err_i) begin
      cyc_d   = 1'b0;
      fault_d = 1'b1;
      state_d = DONE;
    end else if (cyc_q && wb.wb_ack_i) begin
      cyc_d = 1'b0;
      case (state_q)
        INIT_LO:  state_d = INIT_HI;
        INIT_HI:  state_d = INIT_CTR;
        INIT_CTR: state_d = IDLE;
        WR_TXR:   state_d = WR_CR;
        WR_CR:    begin state_d = RD_SR; poll_d = '0; end
        RD_SR: begin
          poll_d = poll_inc;
          if (tip) begin
            if (poll_inc == POLL_LIM) begin fault_d = 1'b1; state_d = STOP_CR; end
          end else if (al) begin
            fault_d = 1'b1;
            state_d = STOP_CR;
          end else if (rxack) begin
            nack_d  = 1'b1;
            state_d = STOP_CR;
          end else if (byte_q == 2'd2) begin
            state_d = DONE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = WR_TXR;
          end
        end
        STOP_CR:  begin state_d = STOP_POLL; poll_d = '0; end
        STOP_POLL: begin
          poll_d = poll_inc;
          if (!tip) state_d = DONE;
          else if (poll_inc == POLL_LIM) begin fault_d = 1'b1; state_d = DONE; end
        end
        default: state_d = state_q;
      endcase
    end

    case (state_q)
      IDLE: if (req_i) begin
        chan_d  = chan_i;
        value_d = value_i;
        byte_d  = 2'd0;
        nack_d  = 1'b0;
        fault_d = 1'b0;
        state_d = WR_TXR;
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= INIT_LO;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      reg_q   <= 3'd0;
      dat_q   <= 8'h00;
      byte_q  <= 2'd0;
      poll_q  <= '0;
      chan_q  <= 2'd0;
      value_q <= 12'h000;
      nack_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      byte_q  <= byte_d;
      poll_q  <= poll_d;
      chan_q  <= chan_d;
      value_q <= value_d;
      nack_q  <= nack_d;
      fault_q <= fault_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = {8'h00, 3'b000, reg_q, 2'b00};
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = {24'h0, dat_q};

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign nack_o  = nack_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_rfp_dac_loader.sv
// Bench for rfp_dac_loader: scripted I2C-core register model on the slave side,
// transaction-level reference model for the expected register access sequence.
module tb_rfp_dac_loader;

  localparam int POLL_MAX = 4;
  localparam int DAC_ADDR = 'h60;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n, req;
  logic [1:0]  chan;
  logic [11:0] value;
  logic        busy, done, nack, fault;

  always #5 clk = ~clk;

  rfp_dac_loader_if wb ();

  rfp_dac_loader #(.POLL_MAX(POLL_MAX)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .req_i   (req),
    .chan_i  (chan),
    .value_i (value),
    .busy_o  (busy),
    .done_o  (done),
    .nack_o  (nack),
    .fault_o (fault),
    .wb      (wb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Written only by the slave/monitor process.
  acc_t log_q[$];
  int   acc_total  = 0;
  int   sr_reads   = 0;
  int   done_total = 0;
  int   viol       = 0;

  // Written only by the stimulus process.
  logic [7:0] sr_script[$];
  logic [7:0] sr_default;
  int         sr_base;
  int         err_abs;

  // Reference model state.
  acc_t       exp_q[$];
  logic [7:0] m_sr[$];
  int         m_n, m_err_at;
  logic       m_nack, m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model of the I2C core registers plus a bus-protocol monitor.
  initial begin
    int         delay = -1;
    logic       p_cyc = 1'b0;
    acc_t       p_bus = '0;
    logic [7:0] sr;
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (done) done_total++;
      if (wb.wb_stb_o !== wb.wb_cyc_o || (wb.wb_cyc_o && wb.wb_sel_o !== 4'hF)) viol++;
      if (wb.wb_cyc_o && (wb.wb_ack_i || wb.wb_err_i)) viol++;
      else if (wb.wb_cyc_o && p_cyc && {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o[7:0]} !== p_bus) viol++;
      p_cyc = wb.wb_cyc_o;
      p_bus = {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o[7:0]};
      if (wb.wb_ack_i || wb.wb_err_i) begin
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
      end else if (wb.wb_cyc_o) begin
        if (delay < 0) delay = int'($urandom_range(0, 2));
        if (delay == 0) begin
          delay = -1;
          sr = (sr_reads - sr_base < sr_script.size()) ? sr_script[sr_reads - sr_base] : sr_default;
          log_q.push_back({wb.wb_we_o, wb.wb_adr_o, wb.wb_we_o ? wb.wb_dat_o[7:0] : sr});
          if (!wb.wb_we_o) begin
            wb.wb_dat_i = {24'h0, sr};
            sr_reads++;
          end
          if (acc_total == err_abs) wb.wb_err_i = 1'b1;
          else wb.wb_ack_i = 1'b1;
          acc_total++;
        end else begin
          delay--;
        end
      end
    end
  end

  function automatic bit add(input logic we, input int r, input logic [7:0] d);
    exp_q.push_back({we, 16'(r * 4), d});
    m_n++;
    return (m_n - 1 == m_err_at);
  endfunction

  function automatic logic [7:0] next_sr();
    if (m_sr.size() > 0) return m_sr.pop_front();
    return sr_default;
  endfunction

  // Expected register traffic for one DAC write, given the SR script and error point.
  task automatic model_txn(input logic [1:0] ch, input logic [11:0] val, input int err_at);
    int         b[3];
    int         cr[3] = '{'h90, 'h10, 'h50};
    logic [7:0] sr;
    int         polls;
    exp_q.delete();
    m_sr = sr_script;
    m_n = 0;
    m_err_at = err_at;
    m_nack = 1'b0;
    m_fault = 1'b0;
    b[0] = DAC_ADDR * 2;
    b[1] = 64 + int'(ch) * 16 + int'(val) / 256;
    b[2] = int'(val) % 256;
    for (int k = 0; k < 3; k++) begin
      if (add(1'b1, 3, 8'(b[k])) || add(1'b1, 4, 8'(cr[k]))) begin m_fault = 1'b1; return; end
      polls = 0;
      do begin
        sr = next_sr();
        polls++;
        if (add(1'b0, 4, sr)) begin m_fault = 1'b1; return; end
      end while (sr[1] && polls < POLL_MAX);
      if (!sr[1] && !sr[5] && !sr[7]) continue;
      if (sr[1] || sr[5]) m_fault = 1'b1;
      else m_nack = 1'b1;
      if (add(1'b1, 4, 8'h40)) begin m_fault = 1'b1; return; end
      polls = 0;
      do begin
        sr = next_sr();
        polls++;
        if (add(1'b0, 4, sr)) begin m_fault = 1'b1; return; end
      end while (sr[1] && polls < POLL_MAX);
      if (sr[1]) m_fault = 1'b1;
      return;
    end
  endtask

  task automatic check_log(input string tag, input int lb);
    int n = log_q.size() - lb;
    check({tag, ":n_acc"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s:acc%0d", tag, i), 32'(log_q[lb + i]), 32'(exp_q[i]));
  endtask

  task automatic check_init(input string tag, input int lb);
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    exp_q.delete();
    exp_q.push_back({1'b1, 16'h0000, 8'hC7});
    exp_q.push_back({1'b1, 16'h0004, 8'h00});
    exp_q.push_back({1'b1, 16'h0008, 8'h80});
    check({tag, ":busy_low"}, 32'(busy), 32'd0);
    check_log(tag, lb);
  endtask

  task automatic run_txn(input string tag, input logic [1:0] ch, input logic [11:0] val,
                         input int err_at, input bit poke);
    int lb, db, vb, t;
    model_txn(ch, val, err_at);
    lb = log_q.size();
    db = done_total;
    vb = viol;
    sr_base = sr_reads;
    err_abs = (err_at < 0) ? -1 : acc_total + err_at;
    @(negedge clk);
    chan = ch;
    value = val;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chan = 2'($urandom);
    value = 12'($urandom);
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":flags_clr"}, 32'({nack, fault}), 32'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    t = 0;
    while (done_total == db && t < 3000) begin @(negedge clk); t++; end
    check({tag, ":done_seen"}, 32'(t < 3000), 32'd1);
    repeat (10) @(negedge clk);
    check({tag, ":done_cnt"}, 32'(done_total - db), 32'd1);
    check({tag, ":nack"}, 32'(nack), 32'(m_nack));
    check({tag, ":fault"}, 32'(fault), 32'(m_fault));
    check({tag, ":idle"}, 32'(busy), 32'd0);
    check({tag, ":protocol"}, 32'(viol - vb), 32'd0);
    check_log(tag, lb);
    err_abs = -1;
  endtask

  initial begin
    int lb, t;
    rst_n = 1'b0;
    req = 1'b0;
    chan = 2'd0;
    value = 12'h000;
    sr_default = 8'h00;
    sr_base = 0;
    err_abs = -1;

    @(negedge clk);
    check("rst:busy", 32'(busy), 32'd1);
    check("rst:cyc_stb_we", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}), 32'd0);
    check("rst:done_nack_fault", 32'({done, nack, fault}), 32'd0);
    check("rst:adr", 32'(wb.wb_adr_o), 32'd0);
    check("rst:dat", wb.wb_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_init("init", 0);

    sr_script = '{8'h02, 8'h02, 8'h00};
    run_txn("basic", 2'd2, 12'hABC, -1, 1'b0);

    sr_script = '{8'h80};
    run_txn("nack", 2'd1, 12'h5A5, -1, 1'b0);

    sr_script.delete();
    sr_default = 8'h02;
    run_txn("timeout", 2'd3, 12'h0F0, -1, 1'b0);
    sr_default = 8'h00;

    run_txn("wb_err", 2'd0, 12'h123, 4, 1'b0);
    run_txn("after_err", 2'd3, 12'hFFF, -1, 1'b0);

    sr_script = '{8'h02, 8'h00, 8'h02, 8'h20};
    run_txn("arb_lost", 2'd1, 12'h800, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] pick[5] = '{8'h02, 8'h00, 8'h00, 8'h80, 8'h20};
      sr_script.delete();
      for (int j = 0; j < int'($urandom_range(0, 5)); j++)
        sr_script.push_back(pick[$urandom_range(0, 4)]);
      run_txn($sformatf("rand%0d", i), 2'($urandom), 12'($urandom), -1, 1'b1);
    end

    // Reset in the middle of an SR poll.
    sr_script.delete();
    sr_default = 8'h02;
    sr_base = sr_reads;
    @(negedge clk);
    req = 1'b1;
    chan = 2'd2;
    value = 12'h321;
    @(negedge clk);
    req = 1'b0;
    t = 0;
    while (!(wb.wb_cyc_o && !wb.wb_we_o && wb.wb_adr_o == 16'h0010) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst:in_poll", 32'(wb.wb_stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst:cyc_stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
    check("mid_rst:busy", 32'(busy), 32'd1);
    sr_default = 8'h00;
    lb = log_q.size();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_init("reinit", lb);

    sr_script.delete();
    run_txn("post_rst", 2'd0, 12'h7E1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rfp_dac_loader.md
# rfp_dac_loader

Autonomous Wishbone master that sits directly upstream of the RFP I2C bridge and drives its DAC-bus I2C core (core select 0). It initialises the core's prescaler and enable after reset, then on each request performs a complete 3-byte I2C write: address, command/high nibble, low byte. It does this purely through register accesses to the core, polling status between bytes. Software can then set RFP DAC channels with a single strobe instead of running the I2C core register by register.

## Interface
- PRESCALE, 16'd199: value written to PRERhi:PRERlo; 100 kHz SCL at 100 MHz.
- DAC_ADDR, 7'h60: 7-bit I2C slave address of the DAC.
- POLL_MAX, 16'd50000: maximum status-register reads per byte before timeout.
- clk_i  in  1  system clock, same clock as the bridge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  1  start request; sampled only in IDLE.
- chan_i  in  2  DAC channel; latched with req_i.
- value_i  in  12  DAC code; latched with req_i.
- busy_o  out  1  high from reset until init completes, and during every transaction.
- done_o  out  1  one-cycle pulse at the end of every transaction, success or fail.
- nack_o  out  1  slave NACKed; valid with done_o, held until next accepted req_i.
- fault_o  out  1  timeout, arbitration lost, or wb_err_i; valid with done_o, held until next accepted req_i.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  16  byte address {8'h00, 3'b000, reg[2:0], 2'b00}; bit 15 always 0.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_o  out  32  {24'h0, byte}.
- wb_dat_i  in  32  read data; only [7:0] used.
- wb_ack_i, wb_err_i  in  1 each  slave responses.

## Operation
- Core register indices:
  - 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR, 4 CR (write) / SR (read).
  - SR bits: [7] RxACK, [5] AL, [1] TIP.
- Init after reset: write PRERlo = PRESCALE[7:0], then PRERhi = PRESCALE[15:8], then CTR = 8'h80. Then go to IDLE; busy_o falls.
- IDLE: when req_i is high, latch chan_i and value_i, clear nack_o and fault_o, and raise busy_o.
- Bytes sent, per byte k = 0..2:
  - B0 = {DAC_ADDR, 1'b0}
  - B1 = {2'b01, chan, value[11:8]}
  - B2 = value[7:0]
- Per-byte sequence:
  1. Write TXR = Bk.
  2. Write CR: 8'h90 for k=0 (STA|WR), 8'h10 for k=1 (WR), 8'h50 for k=2 (STO|WR).
  3. Read SR repeatedly while TIP = 1.
  4. Once TIP = 0: if AL = 1, fail with fault. Otherwise, if RxACK = 1, fail with nack. Otherwise advance to the next byte.
- Poll counter: reset per byte. On reaching POLL_MAX reads with TIP still 1, fail with fault.
- Fail (nack or AL): write CR = 8'h40 (STO), then poll SR until TIP = 0, bounded by POLL_MAX, then finish.
- Wishbone error: wb_err_i on any access aborts immediately to DONE with fault; no STO is issued.
- State machine: INIT_LO → INIT_HI → INIT_CTR → IDLE → WR_TXR → WR_CR → RD_SR → (WR_TXR | STOP_CR | DONE) ; STOP_CR → STOP_POLL → DONE → IDLE.
- DONE pulses done_o for one cycle. busy_o is low in IDLE only.

## Timing
- Reset values: wb_cyc_o, wb_stb_o, wb_we_o, done_o, nack_o, fault_o = 0; wb_adr_o = 0; wb_dat_o = 0; busy_o = 1; state = INIT_LO.
- Access start: wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o and wb_we_o are registered and asserted together.
- Access hold: all of them hold stable until the first clock with wb_ack_i or wb_err_i high.
- Access end: cyc/stb drop on the next clock. At least one idle cycle separates consecutive accesses.
- Read capture: SR is captured from wb_dat_i in the cycle wb_ack_i is high.
- req_i at the exact DONE → IDLE transition is accepted the cycle after IDLE is entered. req_i during busy is ignored; there is no queue.
- Minimum transaction: from req_i accepted to done_o is at least 3 × (TXR + CR + ≥1 SR) accesses, each at least 2 cycles.
- Reset mid-transaction: outputs return to reset values immediately and init reruns. A partial I2C transfer on the bus is not recovered by this block.

## Test plan
- Reset release, bridge model acks in 1 cycle -> exactly 3 writes: adr 16'h0000 data 8'hC7, 16'h0004 data 8'h00, 16'h0008 data 8'h80; then busy_o falls.
- req_i with chan=2, value=12'hABC, SR model returns TIP=1 twice then 8'h00 -> TXR writes 8'hC0, 8'h6A, 8'hBC; CR writes 8'h90, 8'h10, 8'h50; done_o pulses once; nack_o = 0, fault_o = 0.
- SR returns 8'h80 after the first byte -> CR 8'h40 written, polled to TIP=0, done_o with nack_o = 1; no byte-1 TXR write.
- SR held at 8'h02 (POLL_MAX = 4) -> exactly 4 SR reads for the byte, STO issued, done_o with fault_o = 1.
- wb_err_i on the second CR write -> cyc drops next clock, done_o with fault_o = 1, no further accesses; next req_i clears fault_o.
- rst_n_i asserted during an SR poll with wb_stb_o high -> wb_cyc_o/wb_stb_o low the same cycle (asynchronous); init writes repeat after release.
